// File: rtl/vedic_mult_sequencer.sv
// ============================================================================
//  Module   : vedic_mult_sequencer (with helpers vedic_4_x_4, vedic_2_x_2)
//  Purpose  : 8x8 unsigned multiplier that time-shares a single 4x4 Vedic
//             (Urdhva-Tiryagbhyam) multiplier over four cycles, with
//             valid/ready handshakes on both the operand and product sides.
//  Ports    : clk        - sole clock, rising edge
//             rst_n      - synchronous active-low reset
//             in_valid   - operand pair offered
//             in_ready   - block idle, operand pair will be accepted
//             a, b       - 8-bit unsigned operands, sampled on handshake
//             out_valid  - product available
//             out_ready  - consumer takes product
//             p          - 16-bit product (accumulator)
//             busy       - high whenever not idle
//             op_count   - completed output handshakes, modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vedic_2_x_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_lo;
  logic cross_hi;
  logic carry;

  assign cross_lo = a[1] & b[0];
  assign cross_hi = a[0] & b[1];
  assign carry    = cross_lo & cross_hi;

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_lo ^ cross_hi;
  assign p[2] = (a[1] & b[1]) ^ carry;
  assign p[3] = (a[1] & b[1]) & carry;
endmodule

module vedic_4_x_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q_ll;
  logic [3:0] q_hl;
  logic [3:0] q_lh;
  logic [3:0] q_hh;
  logic [7:0] mid;

  vedic_2_x_2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
  vedic_2_x_2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
  vedic_2_x_2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
  vedic_2_x_2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

  // Both cross products carry weight 2^2; add them first with a carry bit.
  assign mid = {1'b0, ({1'b0, q_hl} + {1'b0, q_lh}), 2'b00};
  assign p   = {4'h0, q_ll} + mid + {q_hh, 4'h0};
endmodule

module vedic_mult_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy,
  output logic [7:0]  op_count
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  a_lat;
  logic [7:0]  b_lat;
  logic [15:0] acc;
  logic [1:0]  step;
  logic [7:0]  count;
  logic [3:0]  op_x;
  logic [3:0]  op_y;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;

  vedic_4_x_4 u_core (.a(op_x), .b(op_y), .p(pp));

  // Nibble selection and weighting of the partial product for each step.
  always_comb begin
    op_x       = a_lat[3:0];
    op_y       = b_lat[3:0];
    pp_shifted = {8'h00, pp};
    case (step)
      2'd0: begin
        op_x       = a_lat[3:0];
        op_y       = b_lat[3:0];
        pp_shifted = {8'h00, pp};
      end
      2'd1: begin
        op_x       = a_lat[7:4];
        op_y       = b_lat[3:0];
        pp_shifted = {4'h0, pp, 4'h0};
      end
      2'd2: begin
        op_x       = a_lat[3:0];
        op_y       = b_lat[7:4];
        pp_shifted = {4'h0, pp, 4'h0};
      end
      default: begin
        op_x       = a_lat[7:4];
        op_y       = b_lat[7:4];
        pp_shifted = {pp, 8'h00};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MUL;
      MUL:     if (step == 2'd3) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_lat <= 8'h00;
      b_lat <= 8'h00;
      acc   <= 16'h0000;
      step  <= 2'd0;
      count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat <= a;
            b_lat <= b;
            acc   <= 16'h0000;
            step  <= 2'd0;
          end
        end
        MUL: begin
          // Step wraps back to 0 on the final partial product.
          acc  <= acc + pp_shifted;
          step <= step + 2'd1;
        end
        DONE: begin
          if (out_ready) count <= count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = acc;
  assign op_count  = count;
endmodule

`default_nettype wire

// File: tb/tb_vedic_mult_sequencer.sv
// ============================================================================
//  Module   : tb_vedic_mult_sequencer
//  Purpose  : Self-checking bench for vedic_mult_sequencer; expected products,
//             latencies, issue intervals and handshake counts come from plain
//             arithmetic on the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vedic_mult_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] p;
  logic        busy;
  logic [7:0]  op_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_cnt = 8'h00;

  vedic_mult_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair from IDLE; returns the cycle index of the accept edge.
  task automatic accept(input logic [7:0] av, input logic [7:0] bv, output int t_acc);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step_clk();
    t_acc = cyc;
  endtask

  // After accept: count edges until out_valid, scrambling inputs meanwhile.
  task automatic wait_done(input logic [15:0] expp, input bit hold_valid);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (!hold_valid) in_valid = 1'($urandom);
      step_clk();
      lat++;
      if (out_valid) seen = 1'b1;
      else check("in_ready_mul", {31'd0, in_ready}, 32'd0);
    end
    in_valid = hold_valid;
    check("latency", lat, 32'd4);
    check("product", {16'd0, p}, {16'd0, expp});
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    check("busy_done", {31'd0, busy}, 32'd1);
  endtask

  // Hold out_ready low for some cycles, then complete the output handshake.
  task automatic finish_op(input int hold, input logic [15:0] expp, input bit keep_ready);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      step_clk();
      check("held_valid", {31'd0, out_valid}, 32'd1);
      check("held_p", {16'd0, p}, {16'd0, expp});
    end
    out_ready = 1'b1;
    step_clk();
    exp_cnt = exp_cnt + 8'd1;
    check("valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("op_count", {24'd0, op_count}, {24'd0, exp_cnt});
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    if (!keep_ready) out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_clk();
    rst_n = 1'b1;
    exp_cnt = 8'h00;
  endtask

  initial begin
    int t_acc;
    int t_prev;
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset state
    rst_n = 1'b0;
    step_clk();
    step_clk();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_p", {16'd0, p}, 32'd0);
    check("rst_op_count", {24'd0, op_count}, 32'd0);
    rst_n = 1'b1;
    step_clk();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset abandons an operation mid-multiply (at step 2)
    accept(8'hFF, 8'h02, t_acc);
    in_valid = 1'b0;
    step_clk();
    step_clk();
    rst_n = 1'b0;
    step_clk();
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_p", {16'd0, p}, 32'd0);
    check("abort_op_count", {24'd0, op_count}, 32'd0);
    step_clk();
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    accept(8'h03, 8'h05, t_acc);
    wait_done(16'd15, 1'b0);
    finish_op(0, 16'd15, 1'b0);

    // Max operands, out_ready high before DONE
    out_ready = 1'b1;
    accept(8'hFF, 8'hFF, t_acc);
    wait_done(16'hFE01, 1'b0);
    finish_op(0, 16'hFE01, 1'b0);

    // Zero operand, then a regular pair
    accept(8'h00, 8'hA5, t_acc);
    wait_done(16'h0000, 1'b0);
    finish_op(0, 16'h0000, 1'b0);
    accept(8'h12, 8'h34, t_acc);
    wait_done(16'h03A8, 1'b0);
    finish_op(0, 16'h03A8, 1'b0);

    // Back-pressure: product held while out_ready low, single handshake
    accept(8'h9C, 8'h47, t_acc);
    wait_done(16'h2B44, 1'b0);
    finish_op(3, 16'h2B44, 1'b1);
    step_clk();
    check("single_hs", {24'd0, op_count}, {24'd0, exp_cnt});
    out_ready = 1'b0;

    // Streaming: 256 random operations with in_valid/out_ready held high
    do_reset();
    out_ready = 1'b1;
    t_prev = 0;
    for (int n = 0; n < 256; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      accept(ra, rb, t_acc);
      if (n > 0) check("issue_interval", t_acc - t_prev, 32'd6);
      t_prev = t_acc;
      wait_done(16'(ra) * 16'(rb), 1'b1);
      finish_op(0, 16'(ra) * 16'(rb), 1'b1);
      if (n == 254) check("op_count_255", {24'd0, op_count}, 32'd255);
    end
    check("op_count_wrap", {24'd0, op_count}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
